// File: rtl/des_dout_rd.sv
// Read-side result buffer for the DES engine: 64-bit blocks in, 32-bit words out (low word first).
// Optional build macro DES_DOUT_PARITY_EN forces DES odd parity into bit 0 of every byte on q.

module des_dout_rd #(
   parameter int PTR_W = 2
) (
   input  logic             hclk,
   input  logic             hreset,
   input  logic             clrptr,
   input  logic             blk_vld,
   input  logic [63:0]      blk_data,
   output logic             blk_rdy,
   input  logic             rd,
   output logic [31:0]      q,
   output logic             empty,
   output logic             full,
   output logic [PTR_W:0]   word_cnt,
   output logic             ovf_err,
   output logic             unf_err
);

   localparam int WORDS = 2 ** PTR_W;

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_TWO  = PTR_W'(2);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_TWO  = (PTR_W+1)'(2);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(WORDS);
   localparam logic [PTR_W:0]   CNT_RDY  = (PTR_W+1)'(WORDS - 2);

   logic [31:0]      mem [WORDS];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr_hi;
   logic [PTR_W:0]   cnt_nxt;
   logic             push;
   logic             pop;
   logic [31:0]      head;

   // Handshake: a block transfers on a rising edge where blk_vld && blk_rdy; blk_rdy
   // depends only on registered occupancy, so a same-cycle pop never makes room.
   assign blk_rdy   = (word_cnt <= CNT_RDY);
   assign empty     = (word_cnt == '0);
   assign full      = (word_cnt == CNT_FULL);
   assign push      = blk_vld && blk_rdy;
   assign pop       = rd && !empty;
   assign wr_ptr_hi = wr_ptr + PTR_ONE;
   assign head      = empty ? 32'h0 : mem[rd_ptr];

   always_comb begin
      cnt_nxt = word_cnt;
      case ({push, pop})
         2'b10:   cnt_nxt = word_cnt + CNT_TWO;
         2'b01:   cnt_nxt = word_cnt - CNT_ONE;
         2'b11:   cnt_nxt = word_cnt + CNT_ONE;
         default: cnt_nxt = word_cnt;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         word_cnt <= '0;
         ovf_err  <= 1'b0;
         unf_err  <= 1'b0;
      end else if (!clrptr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         word_cnt <= '0;
         ovf_err  <= 1'b0;
         unf_err  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_TWO;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         word_cnt <= cnt_nxt;
         if (blk_vld && !blk_rdy) ovf_err <= 1'b1;
         if (rd && empty)         unf_err <= 1'b1;
      end
   end

   // Memory survives clrptr; only hreset wipes it. wr_ptr is always even, so a block never wraps.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
      end else if (clrptr && push) begin
         mem[wr_ptr]    <= blk_data[31:0];
         mem[wr_ptr_hi] <= blk_data[63:32];
      end
   end

`ifdef DES_DOUT_PARITY_EN
   always_comb begin
      q = head;
      if (!empty) begin
         for (int b = 0; b < 4; b++) q[8*b] = ~^head[8*b+1 +: 7];
      end
   end
`else
   assign q = head;
`endif

endmodule

// File: tb/tb_des_dout_rd.sv
// Directed bench for des_dout_rd: a word-queue model is checked against the DUT every cycle,
// with literal expectations at key points of each scenario.

module tb_des_dout_rd;

   localparam int PTR_W = 2;
   localparam int WORDS = 4;

   logic          hclk = 1'b0;
   logic          hreset = 1'b1;
   logic          clrptr = 1'b1;
   logic          blk_vld = 1'b0;
   logic [63:0]   blk_data = 64'h0;
   logic          rd = 1'b0;
   logic          blk_rdy;
   logic [31:0]   q;
   logic          empty;
   logic          full;
   logic [PTR_W:0] word_cnt;
   logic          ovf_err;
   logic          unf_err;

   int n_pass  = 0;
   int n_total = 0;

   des_dout_rd #(.PTR_W(PTR_W)) dut (
      .hclk(hclk), .hreset(hreset), .clrptr(clrptr),
      .blk_vld(blk_vld), .blk_data(blk_data), .blk_rdy(blk_rdy),
      .rd(rd), .q(q), .empty(empty), .full(full), .word_cnt(word_cnt),
      .ovf_err(ovf_err), .unf_err(unf_err)
   );

   always #5 hclk = ~hclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   // Model: the FIFO is just an ordered list of stored words plus two sticky flags.
   logic [31:0] exp_q[$];
   bit          m_ovf = 1'b0;
   bit          m_unf = 1'b0;
   bit          m_live = 1'b0;

   function automatic logic [31:0] model_q();
      logic [31:0] w;
      int ones;
      if (exp_q.size() == 0) return 32'h0;
      w = exp_q[0];
`ifdef DES_DOUT_PARITY_EN
      for (int b = 0; b < 4; b++) begin
         ones = 0;
         for (int k = 1; k < 8; k++) ones += int'(w[8*b+k]);
         w[8*b] = (ones % 2 == 0);
      end
`else
      ones = 0;
`endif
      return w;
   endfunction

   always @(posedge hclk) begin
      bit room;
      m_live = 1'b1;
      if (hreset || !clrptr) begin
         exp_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         room = (exp_q.size() <= WORDS - 2);
         if (blk_vld && !room) m_ovf = 1'b1;
         if (rd && exp_q.size() == 0) m_unf = 1'b1;
         if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
         if (blk_vld && room) begin
            exp_q.push_back(blk_data[31:0]);
            exp_q.push_back(blk_data[63:32]);
         end
      end
   end

   always @(negedge hclk) begin
      if (m_live) begin
         check("m_q",       q,                    model_q());
         check("m_cnt",     32'(word_cnt),        32'(exp_q.size()));
         check("m_empty",   {31'b0, empty},       {31'b0, exp_q.size() == 0});
         check("m_full",    {31'b0, full},        {31'b0, exp_q.size() == WORDS});
         check("m_blk_rdy", {31'b0, blk_rdy},     {31'b0, exp_q.size() <= WORDS - 2});
         check("m_ovf",     {31'b0, ovf_err},     {31'b0, m_ovf});
         check("m_unf",     {31'b0, unf_err},     {31'b0, m_unf});
      end
   end

   task automatic cyc(input logic v, input logic [63:0] d, input logic r,
                      input logic c, input logic h);
      blk_vld  = v;
      blk_data = d;
      rd       = r;
      clrptr   = c;
      hreset   = h;
      @(posedge hclk);
      #1;
      blk_vld = 1'b0;
      rd      = 1'b0;
      clrptr  = 1'b1;
      hreset  = 1'b0;
   endtask

   task automatic push(input logic [63:0] d); cyc(1'b1, d, 1'b0, 1'b1, 1'b0); endtask
   task automatic pop();                      cyc(1'b0, 64'h0, 1'b1, 1'b1, 1'b0); endtask
   task automatic clr();                      cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b0); endtask

   initial begin
      cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b1);

      // Some traffic, then a 2-cycle reset that also carries a push and a pop.
      push(64'hCAFEF00D_DEADBEEF);
      push(64'h12345678_9ABCDEF0);
      push(64'h0BADC0DE_FEEDFACE);
      pop();
      pop();
      cyc(1'b1, 64'h11111111_22222222, 1'b1, 1'b1, 1'b1);
      cyc(1'b1, 64'h33333333_44444444, 1'b1, 1'b1, 1'b1);
      check("rst_cnt",   32'(word_cnt),   32'd0);
      check("rst_empty", {31'b0, empty},  32'd1);
      check("rst_q",     q,               32'h0);
      check("rst_rdy",   {31'b0, blk_rdy}, 32'd1);
      check("rst_full",  {31'b0, full},   32'd0);
      check("rst_errs",  {30'b0, ovf_err, unf_err}, 32'd0);

      // Low word first.
      push(64'h01234567_89ABCDEF);
      check("blk_lo", q, 32'h89ABCDEF);
      check("blk_cnt2", 32'(word_cnt), 32'd2);
      pop();
      check("blk_hi", q, 32'h01234567);
      check("blk_cnt1", 32'(word_cnt), 32'd1);
      pop();
      check("blk_cnt0", 32'(word_cnt), 32'd0);
      check("blk_empty", {31'b0, empty}, 32'd1);

      // Fill, overflow drop, drain in order.
      push(64'h02020202_01010101);
      push(64'h08080808_04040404);
      check("fill_full", {31'b0, full}, 32'd1);
      check("fill_rdy",  {31'b0, blk_rdy}, 32'd0);
      push(64'h20202020_10101010);
      check("ovf_set", {31'b0, ovf_err}, 32'd1);
      check("ovf_cnt", 32'(word_cnt), 32'd4);
      check("drain0", q, 32'h01010101); pop();
      check("drain1", q, 32'h02020202); pop();
      check("drain2", q, 32'h04040404); pop();
      check("drain3", q, 32'h08080808); pop();
      check("drain_empty", {31'b0, empty}, 32'd1);
      check("ovf_sticky", {31'b0, ovf_err}, 32'd1);

      // Simultaneous push and pop at count 3 (dropped) and count 1 (accepted).
      clr();
      check("clr_ovf", {31'b0, ovf_err}, 32'd0);
      push(64'h02020202_01010101);
      push(64'h08080808_04040404);
      pop();
      check("sim3_cnt", 32'(word_cnt), 32'd3);
      cyc(1'b1, 64'h20202020_10101010, 1'b1, 1'b1, 1'b0);
      check("sim3_ovf", {31'b0, ovf_err}, 32'd1);
      check("sim3_cnt2", 32'(word_cnt), 32'd2);
      pop();
      check("sim1_head", q, 32'h08080808);
      cyc(1'b1, 64'h80808080_40404040, 1'b1, 1'b1, 1'b0);
      check("sim1_cnt", 32'(word_cnt), 32'd2);
      check("sim1_newq", q, 32'h40404040);

      // Underflow, clear, then wrap across three blocks.
      clr();
      pop();
      check("unf_set", {31'b0, unf_err}, 32'd1);
      check("unf_cnt", 32'(word_cnt), 32'd0);
      clr();
      check("unf_clr", {31'b0, unf_err}, 32'd0);
      push(64'h02020202_01010101);
      push(64'h08080808_04040404);
      pop();
      pop();
      push(64'h80808080_40404040);
      check("wrap0", q, 32'h04040404); pop();
      check("wrap1", q, 32'h08080808); pop();
      check("wrap2", q, 32'h40404040); pop();
      check("wrap3", q, 32'h80808080); pop();
      check("wrap_empty", {31'b0, empty}, 32'd1);

      // All-zero block shows the parity path.
      clr();
      push(64'h0);
`ifdef DES_DOUT_PARITY_EN
      check("par_zero", q, 32'h01010101);
`else
      check("par_zero", q, 32'h0);
`endif
      pop();
      pop();
      check("par_empty_q", q, 32'h0);

      @(posedge hclk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
